mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 12-bit-address data memory between instruction fetch and the ALU/stack data path.
- Arbitrates between the two requesters with round-robin priority and sequences one memory access at a time.
- Forces every 16-bit address onto the 12-bit memory address space by discarding bits [15:12].
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- READ_LATENCY, 1: cycles from the memEn edge until memRData is valid. Legal range 1-4.
- ADDR_BITS, 12: width of memAddr. Address bits above ADDR_BITS-1 are forced to 0.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- fetchReq  in  1  fetch request; held high until fetchAck
- fetchAddr  in  16  fetch address
- fetchAck  out  1  one-cycle pulse; fetch access complete
- fetchData  out  16  fetched word; valid with fetchAck, held until next fetchAck
- dataReq  in  1  data request; held high until dataAck
- dataWe  in  1  1 = write, 0 = read; sampled with dataReq
- dataAddr  in  16  data address
- dataWData  in  16  write data
- dataAck  out  1  one-cycle pulse; data access complete
- dataRData  out  16  read word; valid with dataAck on reads, held until next data read ack
- memEn  out  1  memory enable, high for exactly one cycle per access
- memWe  out  1  memory write enable, qualified by memEn
- memAddr  out  ADDR_BITS  memory address, registered
- memWData  out  16  memory write data, registered
- memRData  in  16  memory read data
- busy  out  1  high in any state other than IDLE
- fault  out  1  see Optional Feature; constant 0 when compiled out

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, lastGrant = DATA, wait counter 0, captured data registers 0.
- FSM states:
  - IDLE: sample requests.
    - Neither high: stay in IDLE.
    - One high: grant it.
    - Both high: grant the requester not in lastGrant. After reset, fetch wins first.
    - On grant: latch address bits [ADDR_BITS-1:0], we (fetch always read) and wdata; update lastGrant; go to ISSUE.
  - ISSUE: memEn=1; memWe=latched we; memAddr/memWData driven from latches.
    - Write, or READ_LATENCY=1: go to ACK.
    - Otherwise: load counter with READ_LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter; go to ACK when it reaches 1. memEn=0.
  - ACK:
    - Pulse the granted requester's ack.
    - On a read, capture memRData into fetchData or dataRData. The captured value is visible in the same cycle as ack through a registered output, updated at the ACK entry edge.
    - Next state IDLE.
- Latency, measured from the edge where IDLE samples the request to the ack cycle:
  - read: READ_LATENCY+1 cycles
  - write: 2 cycles
- Idle gap: one IDLE cycle always separates consecutive accesses. Throughput is at most one access per 3 cycles when READ_LATENCY=1.
- Request dropped before grant: no access.
- Request dropped after grant: the access still completes and ack still pulses.
- Request held high in the cycle after ack: treated as a new request in IDLE. Requesters drop req on ack.
- Inputs changing after grant: fetchAddr, dataAddr, dataWe and dataWData are ignored once granted (they are latched).
- Reset mid-access: memEn and acks drop immediately. The in-flight access is abandoned with no ack.
- Address wrap: 16'hF123 maps to 12'h123.

Optional Feature:
- Macro: MEM_ADDR_FAULT_EN.
- Defined:
  - In IDLE, a granted request whose address bits [15:ADDR_BITS] are non-zero skips ISSUE/WAIT. No memEn.
  - It goes directly to ACK: ack pulses, fault=1 for that cycle, captured data is unchanged.
  - lastGrant still updates.
- Undefined: upper bits are silently forced to 0; fault is tied to 0.

Test Plan:
- Reset with Reset=1 mid-WAIT (READ_LATENCY=3): all outputs read 0 immediately; the next fetchReq is granted with fetch priority.
- Fetch read, READ_LATENCY=1, fetchAddr=16'h0042, memory returns 16'hBEEF: memEn for 1 cycle with memAddr=12'h042; fetchAck 2 cycles after the sample edge with fetchData=16'hBEEF.
- Data write, dataAddr=16'h0100, dataWData=16'h1234: memEn=memWe=1 with memAddr=12'h100; dataAck 2 cycles after the sample edge; fetchData and dataRData unchanged.
- Both requesters held high for 4 accesses: grants alternate fetch, data, fetch, data; exactly one ack per access; no overlap of memEn.
- READ_LATENCY=4, dataAddr=16'hF7FF read: memAddr=12'h7FF; dataAck 5 cycles after the sample edge. With MEM_ADDR_FAULT_EN: no memEn; dataAck and fault high 1 cycle after the sample edge.
- dataReq pulsed for 1 cycle while fetch owns the bus: no data access occurs and dataAck stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester handshakes plus the memory port of mem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory environment.
interface mem_port_arbiter_if #(
   parameter int ADDR_BITS = 12
);
   logic                 fetchReq;
   logic [15:0]          fetchAddr;
   logic                 fetchAck;
   logic [15:0]          fetchData;

   logic                 dataReq;
   logic                 dataWe;
   logic [15:0]          dataAddr;
   logic [15:0]          dataWData;
   logic                 dataAck;
   logic [15:0]          dataRData;

   logic                 memEn;
   logic                 memWe;
   logic [ADDR_BITS-1:0] memAddr;
   logic [15:0]          memWData;
   logic [15:0]          memRData;

   logic                 busy;
   logic                 fault;

   modport slave (
      input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, memRData,
      output fetchAck, fetchData, dataAck, dataRData, memEn, memWe, memAddr, memWData,
             busy, fault
   );

   modport master (
      output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWData, memRData,
      input  fetchAck, fetchData, dataAck, dataRData, memEn, memWe, memAddr, memWData,
             busy, fault
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data sharing of one memory port; read ack READ_LATENCY+1 cycles after grant, write ack 2; req held until ack.
// MEM_ADDR_FAULT_EN: out-of-range addresses are acked with fault and no memory access.
module mem_port_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_BITS    = 12
) (
   input logic               CLK,
   input logic               Reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t               state_q;
   logic                 last_data_q;
   logic                 sel_data_q;
   logic                 we_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 mem_en_q;
   logic                 mem_we_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic [15:0]          mem_wdata_q;
   logic                 fetch_ack_q;
   logic                 data_ack_q;
   logic [15:0]          fetch_data_q;
   logic [15:0]          data_rdata_q;
   logic                 busy_q;

   logic                 grant_fetch_d;
   logic                 grant_data_d;
   logic                 grant_we_d;
   logic [15:0]          grant_addr_d;
   logic                 enter_ack_d;

   always_comb begin
      grant_fetch_d = bus.fetchReq && (!bus.dataReq || last_data_q);
      grant_data_d  = bus.dataReq && !grant_fetch_d;
      grant_addr_d  = grant_data_d ? bus.dataAddr : bus.fetchAddr;
      grant_we_d    = grant_data_d && bus.dataWe;
      // Memory data is valid on the edge READ_LATENCY cycles after memEn rose.
      enter_ack_d   = ((state_q == ISSUE) && (we_q || (READ_LATENCY == 1))) ||
                      ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
   end

`ifdef MEM_ADDR_FAULT_EN
   logic fault_q;
`else
   logic unused_grant_addr;
   assign unused_grant_addr = ^grant_addr_d;
`endif

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         last_data_q  <= 1'b1;
         sel_data_q   <= 1'b0;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fetch_ack_q  <= 1'b0;
         data_ack_q   <= 1'b0;
         fetch_data_q <= '0;
         data_rdata_q <= '0;
         busy_q       <= 1'b0;
`ifdef MEM_ADDR_FAULT_EN
         fault_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_fetch_d || grant_data_d) begin
                  last_data_q <= grant_data_d;
                  sel_data_q  <= grant_data_d;
                  we_q        <= grant_we_d;
                  mem_addr_q  <= grant_addr_d[ADDR_BITS-1:0];
                  if (grant_data_d) begin
                     mem_wdata_q <= bus.dataWData;
                  end
                  busy_q <= 1'b1;
`ifdef MEM_ADDR_FAULT_EN
                  if ((grant_addr_d >> ADDR_BITS) != 16'd0) begin
                     state_q     <= ACK;
                     fault_q     <= 1'b1;
                     fetch_ack_q <= grant_fetch_d;
                     data_ack_q  <= grant_data_d;
                  end else
`endif
                  begin
                     state_q  <= ISSUE;
                     mem_en_q <= 1'b1;
                     mem_we_q <= grant_we_d;
                  end
               end
            end
            ISSUE: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               if (!enter_ack_d) begin
                  cnt_q   <= CNT_W'(READ_LATENCY - 1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
            ACK: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               fetch_ack_q <= 1'b0;
               data_ack_q  <= 1'b0;
`ifdef MEM_ADDR_FAULT_EN
               fault_q     <= 1'b0;
`endif
            end
            default: state_q <= IDLE;
         endcase

         if (enter_ack_d) begin
            state_q     <= ACK;
            fetch_ack_q <= !sel_data_q;
            data_ack_q  <= sel_data_q;
            if (!we_q) begin
               if (sel_data_q) begin
                  data_rdata_q <= bus.memRData;
               end else begin
                  fetch_data_q <= bus.memRData;
               end
            end
         end
      end
   end

   assign bus.memEn     = mem_en_q;
   assign bus.memWe     = mem_we_q;
   assign bus.memAddr   = mem_addr_q;
   assign bus.memWData  = mem_wdata_q;
   assign bus.fetchAck  = fetch_ack_q;
   assign bus.dataAck   = data_ack_q;
   assign bus.fetchData = fetch_data_q;
   assign bus.dataRData = data_rdata_q;
   assign bus.busy      = busy_q;
`ifdef MEM_ADDR_FAULT_EN
   assign bus.fault     = fault_q;
`else
   assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: READ_LATENCY=1 instance driven through a scoreboard,
// READ_LATENCY=4 instance for mid-WAIT reset and address-wrap latency.
module tb_mem_port_arbiter;
`ifdef MEM_ADDR_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic CLK   = 1'b0;
   logic Reset = 1'b0;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_BITS(12)) ifa ();
   mem_port_arbiter_if #(.ADDR_BITS(12)) ifb ();

   mem_port_arbiter #(.READ_LATENCY(1), .ADDR_BITS(12)) u_dut_a (
      .CLK(CLK), .Reset(Reset), .bus(ifa)
   );
   mem_port_arbiter #(.READ_LATENCY(4), .ADDR_BITS(12)) u_dut_b (
      .CLK(CLK), .Reset(Reset), .bus(ifb)
   );

   logic [15:0] mem_a [4096];
   logic [15:0] mem_b [4096];
   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [15:0] pre_dat = '0;

   always @(posedge CLK) begin
      if (pre_we) mem_a[pre_addr] <= pre_dat;
      else if (ifa.memEn && ifa.memWe) mem_a[ifa.memAddr] <= ifa.memWData;
   end
   assign ifa.memRData = mem_a[ifa.memAddr];
   assign ifb.memRData = mem_b[ifb.memAddr];

   typedef struct {
      logic        is_data;
      logic        fault;
      int          cyc;
      logic [15:0] fdata;
      logic [15:0] ddata;
   } ack_exp_t;
   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [15:0] wdata;
   } mem_exp_t;

   ack_exp_t    ack_q[$];
   mem_exp_t    mem_q[$];
   logic [15:0] exp_fdata = '0;
   logic [15:0] exp_ddata = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   function automatic logic any_out_a();
      return |{ifa.fetchAck, ifa.fetchData, ifa.dataAck, ifa.dataRData, ifa.memEn,
               ifa.memWe, ifa.memAddr, ifa.memWData, ifa.busy, ifa.fault};
   endfunction

   function automatic logic any_out_b();
      return |{ifb.fetchAck, ifb.fetchData, ifb.dataAck, ifb.dataRData, ifb.memEn,
               ifb.memWe, ifb.memAddr, ifb.memWData, ifb.busy, ifb.fault};
   endfunction

   task automatic exp_ack(input logic is_data, input logic we, input logic [15:0] rd,
                          input int at, input logic flt);
      ack_exp_t e;
      if (!flt && !we) begin
         if (is_data) exp_ddata = rd;
         else exp_fdata = rd;
      end
      e.is_data = is_data;
      e.fault   = flt;
      e.cyc     = at;
      e.fdata   = exp_fdata;
      e.ddata   = exp_ddata;
      ack_q.push_back(e);
   endtask

   task automatic exp_mem(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      mem_exp_t m;
      m.we    = we;
      m.addr  = addr[11:0];
      m.wdata = wdata;
      mem_q.push_back(m);
   endtask

   task automatic preload(input logic [11:0] a, input logic [15:0] d);
      pre_we = 1'b1; pre_addr = a; pre_dat = d;
      step();
      pre_we = 1'b0;
   endtask

   // Waits for the ack, then one more cycle so the arbiter is back in IDLE.
   task automatic drain();
      for (int i = 0; i < 24 && (ack_q.size() != 0 || mem_q.size() != 0); i++) step();
      chk("drain_ack_q", ack_q.size(), 0);
      chk("drain_mem_q", mem_q.size(), 0);
      step();
   endtask

   task automatic fetch_a(input logic [15:0] addr, input logic [15:0] rd, input logic flt);
      int n;
      n = cyc;
      ifa.fetchReq = 1'b1; ifa.fetchAddr = addr;
      if (!flt) exp_mem(1'b0, addr, 16'h0);
      exp_ack(1'b0, 1'b0, rd, flt ? n + 1 : n + 2, flt);
      step();
      ifa.fetchReq = 1'b0; ifa.fetchAddr = ~addr;
      drain();
   endtask

   task automatic data_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rd);
      int n;
      n = cyc;
      ifa.dataReq = 1'b1; ifa.dataWe = we; ifa.dataAddr = addr; ifa.dataWData = wdata;
      exp_mem(we, addr, wdata);
      exp_ack(1'b1, we, rd, n + 2, 1'b0);
      step();
      ifa.dataReq = 1'b0; ifa.dataWe = ~we; ifa.dataAddr = ~addr; ifa.dataWData = ~wdata;
      drain();
   endtask

   task automatic wait_b(output int at, output logic fa, output logic da, output logic flt,
                         output logic saw_en, output logic [11:0] en_addr);
      at = -1; fa = 1'b0; da = 1'b0; flt = 1'b0; saw_en = 1'b0; en_addr = '0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (ifb.memEn) begin
            saw_en  = 1'b1;
            en_addr = ifb.memAddr;
         end
         if (ifb.fetchAck || ifb.dataAck) begin
            at = cyc; fa = ifb.fetchAck; da = ifb.dataAck; flt = ifb.fault;
            break;
         end
      end
   endtask

   logic prev_en_a = 1'b0;
   always @(negedge CLK) begin
      ack_exp_t ea;
      mem_exp_t em;
      int       sz;
      if (!Reset) begin
         if (ifa.fetchAck || ifa.dataAck) begin
            chk("ack_onehot", ifa.fetchAck & ifa.dataAck, 0);
            sz = ack_q.size();
            chk("ack_expected", sz != 0, 1);
            if (sz != 0) begin
               ea = ack_q.pop_front();
               chk("ack_is_data", ifa.dataAck, ea.is_data);
               chk("ack_cycle", cyc, ea.cyc);
               chk("fetchData", ifa.fetchData, ea.fdata);
               chk("dataRData", ifa.dataRData, ea.ddata);
               chk("fault", ifa.fault, ea.fault);
            end
         end
         if (ifa.memEn) begin
            chk("memEn_one_cycle", prev_en_a, 0);
            sz = mem_q.size();
            chk("mem_expected", sz != 0, 1);
            if (sz != 0) begin
               em = mem_q.pop_front();
               chk("memWe", ifa.memWe, em.we);
               chk("memAddr", ifa.memAddr, em.addr);
               if (em.we) chk("memWData", ifa.memWData, em.wdata);
            end
         end
      end
      prev_en_a <= ifa.memEn;
   end

   initial begin
      int          n;
      int          at;
      logic        fa, da, flt, saw_en, seen;
      logic [11:0] en_addr;

      ifa.fetchReq = 0; ifa.fetchAddr = 0; ifa.dataReq = 0; ifa.dataWe = 0;
      ifa.dataAddr = 0; ifa.dataWData = 0;
      ifb.fetchReq = 0; ifb.fetchAddr = 0; ifb.dataReq = 0; ifb.dataWe = 0;
      ifb.dataAddr = 0; ifb.dataWData = 0;
      mem_b[12'h011] = 16'hCAFE;
      mem_b[12'h7FF] = 16'h7777;
      #2 Reset = 1'b1;
      step();
      preload(12'h042, 16'hBEEF);
      preload(12'h010, 16'h5A5A);
      preload(12'h123, 16'h0F0F);
      chk("reset_outs_a", any_out_a(), 0);
      chk("reset_outs_b", any_out_b(), 0);
      Reset = 1'b0;
      step();
      chk("post_reset_outs_a", any_out_a(), 0);
      chk("post_reset_outs_b", any_out_b(), 0);

      // Reset while the RL=4 instance sits in WAIT.
      ifb.fetchReq = 1'b1; ifb.fetchAddr = 16'h0011;
      step();
      chk("b_issue_memEn", ifb.memEn, 1);
      chk("b_issue_memAddr", ifb.memAddr, 12'h011);
      step();
      chk("b_wait_busy", ifb.busy, 1);
      chk("b_wait_memEn", ifb.memEn, 0);
      Reset = 1'b1;
      #1;
      chk("b_midwait_reset_outs", any_out_b(), 0);
      ifb.fetchReq = 1'b0;
      step();
      step();
      Reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen = seen | ifb.fetchAck | ifb.dataAck | ifb.memEn;
      end
      chk("b_abandoned_no_activity", seen, 0);

      // Both requesters after reset: fetch first, then the wrapped data read.
      n = cyc;
      ifb.fetchReq = 1'b1; ifb.fetchAddr = 16'h0011;
      ifb.dataReq = 1'b1; ifb.dataWe = 1'b0; ifb.dataAddr = 16'hF7FF;
      wait_b(at, fa, da, flt, saw_en, en_addr);
      chk("b_first_fetchAck", fa, 1);
      chk("b_first_dataAck", da, 0);
      chk("b_fetch_latency", at, n + 5);
      chk("b_fetch_memAddr", en_addr, 12'h011);
      chk("b_fetchData", ifb.fetchData, 16'hCAFE);
      ifb.fetchReq = 1'b0;
      n = cyc + 1;
      wait_b(at, fa, da, flt, saw_en, en_addr);
      ifb.dataReq = 1'b0;
      chk("b_wrap_dataAck", da, 1);
      chk("b_wrap_latency", at, FAULT_EN ? n + 1 : n + 5);
      chk("b_wrap_memEn", saw_en, !FAULT_EN);
      chk("b_wrap_memAddr", en_addr, FAULT_EN ? 12'h000 : 12'h7FF);
      chk("b_wrap_fault", flt, FAULT_EN);
      chk("b_wrap_dataRData", ifb.dataRData, FAULT_EN ? 16'h0000 : 16'h7777);
      step();

      // RL=1 instance: single accesses.
      fetch_a(16'h0042, 16'hBEEF, 1'b0);
      data_a(1'b1, 16'h0100, 16'h1234, 16'h0);
      data_a(1'b0, 16'h0100, 16'h0, 16'h1234);

      // Both held high: strict alternation starting with fetch.
      n = cyc;
      ifa.fetchReq = 1'b1; ifa.fetchAddr = 16'h0042;
      ifa.dataReq = 1'b1; ifa.dataWe = 1'b0; ifa.dataAddr = 16'h0100;
      for (int k = 0; k < 4; k++) begin
         exp_mem(1'b0, k[0] ? 16'h0100 : 16'h0042, 16'h0);
         exp_ack(k[0], 1'b0, k[0] ? 16'h1234 : 16'hBEEF, n + 2 + 3 * k, 1'b0);
      end
      for (int i = 0; i < 30 && ack_q.size() != 0; i++) step();
      ifa.fetchReq = 1'b0; ifa.dataReq = 1'b0;
      chk("rr_all_acked", ack_q.size(), 0);
      step();

      // One-cycle data pulse while fetch owns the port is never served.
      n = cyc;
      ifa.fetchReq = 1'b1; ifa.fetchAddr = 16'h0010;
      exp_mem(1'b0, 16'h0010, 16'h0);
      exp_ack(1'b0, 1'b0, 16'h5A5A, n + 2, 1'b0);
      step();
      ifa.fetchReq = 1'b0;
      ifa.dataReq = 1'b1; ifa.dataWe = 1'b0; ifa.dataAddr = 16'h0123;
      step();
      ifa.dataReq = 1'b0;
      seen = ifa.dataAck;
      for (int i = 0; i < 6; i++) begin
         step();
         seen = seen | ifa.dataAck;
      end
      chk("pulse_no_dataAck", seen, 0);
      chk("pulse_fetch_acked", ack_q.size(), 0);

      // Upper address bits discarded (or faulted when the check is built in).
      fetch_a(16'hF123, 16'h0F0F, FAULT_EN);
      step();
      chk("final_ack_q", ack_q.size(), 0);
      chk("final_mem_q", mem_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
